// File: rtl/stream_ctrl_if.sv
// stream_ctrl port bundle: producer, buffer and status signals.
// limit exists only when STREAM_CTRL_AUTOSTOP_EN is defined.
interface stream_ctrl_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        start;
  logic                   stop;
  logic [N_CH-1:0]        src_valid;
  logic [N_CH*DATA_W-1:0] src_data;
  logic                   buf_full;
  logic                   buf_empty;
  logic                   rd_valid;
`ifdef STREAM_CTRL_AUTOSTOP_EN
  logic [CNT_W-1:0]       limit;
`endif
  logic [N_CH-1:0]        src_en;
  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic [CH_W-1:0]        ch;
  logic [1:0]             state;
  logic [CNT_W-1:0]       word_cnt;
  logic                   done;

  modport master (
    input  start, stop, src_valid, src_data,
    input  buf_full, buf_empty, rd_valid,
`ifdef STREAM_CTRL_AUTOSTOP_EN
    input  limit,
`endif
    output src_en, wr_en, wr_data, ch,
    output state, word_cnt, done
  );

  modport slave (
    output start, stop, src_valid, src_data,
    output buf_full, buf_empty, rd_valid,
`ifdef STREAM_CTRL_AUTOSTOP_EN
    output limit,
`endif
    input  src_en, wr_en, wr_data, ch,
    input  state, word_cnt, done
  );
endinterface

// File: rtl/stream_ctrl.sv
// Session controller muxing one of N_CH producers onto the buffer write port.
// Optional auto-stop on word count: define STREAM_CTRL_AUTOSTOP_EN.
module stream_ctrl #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  stream_ctrl_if.master io
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [N_CH-1:0]   start_prev_q;
  logic              stop_prev_q;

  logic [N_CH-1:0]   start_edge;
  logic              stop_edge;
  logic [CH_W-1:0]   first_ch;
  logic              run;
  logic              wr;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;

  assign start_edge = io.start & ~start_prev_q;
  assign stop_edge  = io.stop & ~stop_prev_q;

  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (start_edge[i]) first_ch = CH_W'(i);
    end
  end

  // rst gates the producer path so it is cut in the reset cycle itself
  assign run      = (state_q == RUN) & ~rst;
  assign sel_data = io.src_data[ch_q*DATA_W +: DATA_W];
  assign wr       = run & io.src_valid[ch_q] & ~io.buf_full;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef STREAM_CTRL_AUTOSTOP_EN
  assign hit = wr & (io.limit != '0) & (cnt_inc == io.limit);
`else
  assign hit = 1'b0;
`endif

  assign io.src_en   = run ? (N_CH'(1) << ch_q) : '0;
  assign io.wr_en    = wr;
  assign io.wr_data  = wr ? sel_data : '0;
  assign io.ch       = ch_q;
  assign io.state    = state_q;
  assign io.word_cnt = cnt_q;
  assign io.done     = done_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|start_edge) begin
          state_d = RUN;
          ch_d    = first_ch;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (wr) cnt_d = cnt_inc;
        if (stop_edge || hit) state_d = DRAIN;
        else if (io.buf_full) state_d = STALL;
      end
      STALL: begin
        if (stop_edge)         state_d = DRAIN;
        else if (!io.buf_full) state_d = RUN;
      end
      DRAIN: begin
        if (io.buf_empty && !io.rd_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ch_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // prev registers reset high: a level held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      start_prev_q <= '1;
      stop_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      start_prev_q <= io.start;
      stop_prev_q  <= io.stop;
    end
  end
endmodule

// File: tb/tb_stream_ctrl.sv
// Directed + randomized bench for stream_ctrl against a session-level model.
// Autostop steps compile only when STREAM_CTRL_AUTOSTOP_EN is defined.
module tb_stream_ctrl;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_ctrl_if #(.N_CH(N), .DATA_W(DW), .CNT_W(CW)) io ();

  stream_ctrl #(.N_CH(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.master)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // session model: phase 0 idle, 1 writing, 2 waiting on full, 3 draining
  int        m_phase = 0;
  int        m_ch    = 0;
  int        m_cnt   = 0;
  bit        m_done  = 1'b0;
  bit [1:0]  m_sprev = 2'b11;
  bit        m_pprev = 1'b1;
  // producer 0: Fibonacci; producer 1: counter from 0x100
  int        fa = 1, fb = 1, p1 = 'h100;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      bit        run, e_wr, se_any, pe, hit;
      bit [1:0]  se;
      int        e_src, e_data, nxt;
      io.src_data = {p1[15:0], fa[15:0]};
      #1;
      run    = (m_phase == 1) && !rst;
      e_src  = run ? (1 << m_ch) : 0;
      e_wr   = run && io.src_valid[m_ch] && !io.buf_full;
      e_data = e_wr ? ((m_ch == 0) ? (fa & 'hffff) : (p1 & 'hffff)) : 0;
      if (chk_en) begin
        chk("state",    io.state,    m_phase);
        chk("ch",       io.ch,       m_ch);
        chk("word_cnt", io.word_cnt, m_cnt);
        chk("done",     io.done,     m_done);
        chk("src_en",   io.src_en,   e_src);
        chk("wr_en",    io.wr_en,    e_wr);
        chk("wr_data",  io.wr_data,  e_data);
      end
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_ch = 0; m_cnt = 0; m_done = 0;
        m_sprev = 2'b11; m_pprev = 1'b1;
      end else begin
        se = io.start & ~m_sprev;
        pe = io.stop & ~m_pprev;
        m_sprev = io.start;
        m_pprev = io.stop;
        m_done = 1'b0;
        se_any = (se != 0);
        nxt = (m_cnt == 'hffff) ? m_cnt : m_cnt + 1;
        hit = 1'b0;
`ifdef STREAM_CTRL_AUTOSTOP_EN
        hit = e_wr && (io.limit != 0) && (nxt == int'(io.limit));
`endif
        case (m_phase)
          0: if (se_any) begin m_phase = 1; m_ch = lowest(se); m_cnt = 0; end
          1: begin
            if (e_wr) m_cnt = nxt;
            if (pe || hit) m_phase = 3;
            else if (io.buf_full) m_phase = 2;
          end
          2: if (pe) m_phase = 3; else if (!io.buf_full) m_phase = 1;
          default: if (io.buf_empty && !io.rd_valid) begin
            m_phase = 0; m_done = 1'b1; m_ch = 0;
          end
        endcase
      end
      if (e_wr) begin
        if (m_ch == 0) begin
          int t;
          t = (fa + fb) & 'hffff; fa = fb; fb = t;
        end else p1 = (p1 + 1) & 'hffff;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    io.start = '0; io.stop = 1'b1; io.src_valid = '0;
    io.src_data = '0; io.buf_full = 1'b0; io.buf_empty = 1'b1;
    io.rd_valid = 1'b0;
`ifdef STREAM_CTRL_AUTOSTOP_EN
    io.limit = '0;
`endif
    @(negedge clk);
    cyc();
    chk_en = 1'b1;
    cyc();
    // stop held high across reset: no edge afterwards
    rst = 1'b0;
    cyc();
    io.start = 2'b01; io.src_valid = 2'b01; io.buf_empty = 1'b0;
    cyc(6);
    chk("plan_cnt5", io.word_cnt, 5);
    chk("plan_run",  io.state, 1);
    // start[1] during RUN is ignored
    io.start = 2'b11;
    cyc(2);
    io.stop = 1'b0;
    cyc();
    io.buf_full = 1'b1;
    cyc(4);
    chk("plan_stall", io.state, 2);
    io.buf_full = 1'b0;
    cyc(3);
    io.stop = 1'b1;
    cyc(3);
    io.buf_empty = 1'b1; io.rd_valid = 1'b1;
    cyc(2);
    io.rd_valid = 1'b0;
    cyc();
    chk("plan_done", io.done, 1);
    cyc(2);
    // simultaneous starts pick channel 0
    io.start = 2'b00; io.stop = 1'b0;
    cyc();
    io.start = 2'b11;
    cyc(3);
    chk("plan_ch0", io.ch, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(2);
    // channel 1 session
    io.start = 2'b00;
    cyc();
    io.start = 2'b10; io.src_valid = 2'b10;
    cyc(4);
    io.stop = 1'b1;
    cyc(3);
`ifdef STREAM_CTRL_AUTOSTOP_EN
    io.stop = 1'b0; io.start = 2'b00; io.limit = 16'd3;
    io.src_valid = 2'b01;
    cyc();
    io.start = 2'b01;
    cyc(8);
    io.start = 2'b00; io.limit = 16'd0;
    cyc();
    io.start = 2'b01;
    cyc(105);
    chk("auto_off", io.state, 1);
    io.stop = 1'b1;
    cyc(3);
`endif
    for (int r = 0; r < 800; r++) begin
      rst = ($urandom_range(0, 96) == 0);
      if ($urandom_range(0, 4) == 0) io.start = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) io.stop = ~io.stop;
      io.src_valid = 2'($urandom_range(0, 3));
      io.buf_full  = ($urandom_range(0, 3) == 0);
      io.buf_empty = ($urandom_range(0, 1) == 0);
      io.rd_valid  = ($urandom_range(0, 2) == 0);
`ifdef STREAM_CTRL_AUTOSTOP_EN
      if ($urandom_range(0, 15) == 0) io.limit = 16'($urandom_range(0, 6));
`endif
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
